// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Brief    : Debounces a multiplexed 7-segment scan bus, rebuilds five-digit
//            frames and decodes the free-space and nearest-slot digits.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int STABLE      = 4,
    parameter int TIMEOUT     = 1000,
    parameter int SPACE_DIGIT = 0,
    parameter int SLOT_DIGIT  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] seg_select,
    input  logic [7:0] seg_data,
    output logic [2:0] space_count,
    output logic [1:0] near_slot,
    output logic       frame_valid,
    output logic       decode_err,
    output logic       link_lost
);

    localparam int              c_TW        = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      c_STABLE    = 4'(STABLE);
    localparam logic [3:0]      c_STABLE_M1 = 4'(STABLE - 1);
    localparam logic [c_TW-1:0] c_TIMEOUT   = c_TW'(TIMEOUT);
    localparam logic [c_TW-1:0] c_TONE      = c_TW'(1);
    localparam logic [3:0]      c_BLANK     = 4'hA;
    localparam logic [3:0]      c_ILLEGAL   = 4'hF;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_COMMIT  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [4:0]      r_sel;
    logic [4:0]      r_prev_sel;
    logic [6:0]      r_dat;
    logic [6:0]      r_prev_dat;
    logic [3:0]      r_stab;
    logic [4:0]      r_seen;
    logic [6:0]      r_slot [5];
    logic [c_TW-1:0] r_tcnt;

    logic            w_onehot;
    logic            w_same;
    logic            w_accept;
    logic [4:0]      w_acc_mask;
    logic [3:0]      w_space_val;
    logic [3:0]      w_slot_val;
    logic            w_space_ok;
    logic            w_slot_ok;
    logic [c_TW-1:0] w_tcnt_inc;
    logic            w_unused;

    // Decimal point is carried on the bus but has no meaning here.
    assign w_unused = seg_data[7];

    function automatic logic [3:0] f_decode(input logic [6:0] pat);
        case (pat)
            7'h3F:   f_decode = 4'd0;
            7'h06:   f_decode = 4'd1;
            7'h5B:   f_decode = 4'd2;
            7'h4F:   f_decode = 4'd3;
            7'h66:   f_decode = 4'd4;
            7'h6D:   f_decode = 4'd5;
            7'h7D:   f_decode = 4'd6;
            7'h07:   f_decode = 4'd7;
            7'h7F:   f_decode = 4'd8;
            7'h6F:   f_decode = 4'd9;
            7'h00:   f_decode = c_BLANK;
            default: f_decode = c_ILLEGAL;
        endcase
    endfunction

    assign w_onehot   = (r_sel != 5'd0) && ((r_sel & (r_sel - 5'd1)) == 5'd0);
    assign w_same     = (r_sel == r_prev_sel) && (r_dat == r_prev_dat);
    // Fires only on the step into STABLE, so a held pattern is taken once.
    assign w_accept   = w_onehot && w_same && (r_stab == c_STABLE_M1);
    assign w_acc_mask = w_accept ? r_sel : 5'd0;

    assign w_space_val = f_decode(r_slot[SPACE_DIGIT]);
    assign w_slot_val  = f_decode(r_slot[SLOT_DIGIT]);
    assign w_space_ok  = (w_space_val <= 4'd7);
    assign w_slot_ok   = (w_slot_val <= 4'd3);

    assign w_tcnt_inc  = (r_tcnt == c_TIMEOUT) ? r_tcnt : (r_tcnt + c_TONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = ST_COLLECT;
        case (r_state)
            ST_COLLECT: begin
                if (&(r_seen | w_acc_mask)) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: w_state_next = ST_COLLECT;
            default:   w_state_next = ST_COLLECT;
        endcase
    end

    generate
        for (genvar i = 0; i < 5; i++) begin : g_slot
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_slot[i] <= 7'd0;
                end else if (w_acc_mask[i]) begin
                    r_slot[i] <= r_dat;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sel       <= 5'd0;
            r_prev_sel  <= 5'd0;
            r_dat       <= 7'd0;
            r_prev_dat  <= 7'd0;
            r_stab      <= 4'd0;
            r_seen      <= 5'd0;
            r_tcnt      <= '0;
            space_count <= 3'd0;
            near_slot   <= 2'd0;
            frame_valid <= 1'b0;
            decode_err  <= 1'b0;
            link_lost   <= 1'b0;
        end else begin
            r_sel      <= seg_select;
            r_dat      <= seg_data[6:0];
            r_prev_sel <= r_sel;
            r_prev_dat <= r_dat;

            if (!w_onehot) begin
                r_stab <= 4'd0;
            end else if (w_same) begin
                if (r_stab != c_STABLE) begin
                    r_stab <= r_stab + 4'd1;
                end
            end else begin
                r_stab <= 4'd1;
            end

            frame_valid <= 1'b0;
            if (r_state == ST_COMMIT) begin
                // A digit landing now belongs to the next frame.
                r_seen      <= w_acc_mask;
                frame_valid <= 1'b1;
                r_tcnt      <= '0;
                link_lost   <= 1'b0;
                if (w_space_ok) begin
                    space_count <= w_space_val[2:0];
                end else begin
                    decode_err <= 1'b1;
                end
                if (w_slot_ok) begin
                    near_slot <= w_slot_val[1:0];
                end else begin
                    decode_err <= 1'b1;
                end
            end else begin
                r_seen    <= r_seen | w_acc_mask;
                r_tcnt    <= w_tcnt_inc;
                link_lost <= (w_tcnt_inc == c_TIMEOUT);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// Bench for seg_scan_decoder: directed scan frames, expected commits queued
// by the stimulus and checked by an independent monitor on frame_valid.
module tb_seg_scan_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] seg_select = 5'd0;
    logic [7:0] seg_data = 8'd0;
    logic [2:0] space_count;
    logic [1:0] near_slot;
    logic       frame_valid;
    logic       decode_err;
    logic       link_lost;

    seg_scan_decoder #(
        .STABLE      (4),
        .TIMEOUT     (1000),
        .SPACE_DIGIT (0),
        .SLOT_DIGIT  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_select  (seg_select),
        .seg_data    (seg_data),
        .space_count (space_count),
        .near_slot   (near_slot),
        .frame_valid (frame_valid),
        .decode_err  (decode_err),
        .link_lost   (link_lost)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sp;
        logic [1:0] sl;
        logic       err;
        logic       prev_link;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_pulses  = 0;
    logic last_link = 1'b0;

    function automatic void chk(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    task automatic push_exp(input int sp, input int sl, input int err, input int pl);
        exp_t e;
        e.sp        = 3'(sp);
        e.sl        = 2'(sl);
        e.err       = 1'(err);
        e.prev_link = 1'(pl);
        exp_q.push_back(e);
    endtask

    // Monitor: every frame_valid cycle must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_valid) begin
                n_pulses++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("space_count", int'(space_count), int'(e.sp));
                    chk("near_slot", int'(near_slot), int'(e.sl));
                    chk("decode_err", int'(decode_err), int'(e.err));
                    chk("link_lost_at_commit", int'(link_lost), 0);
                    chk("link_lost_before_commit", int'(last_link), int'(e.prev_link));
                end
            end
            last_link = link_lost;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic put(input logic [4:0] sel, input logic [7:0] dat, input int n);
        seg_select = sel;
        seg_data   = dat;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                         input logic [6:0] p3, input logic [6:0] p4, input int h0);
        put(5'b00001, {1'b0, p0}, h0);
        put(5'b00010, {1'b1, p1}, 8);
        put(5'b00100, {1'b0, p2}, 8);
        put(5'b01000, {1'b1, p3}, 8);
        put(5'b10000, {1'b0, p4}, 8);
        put(5'b00000, 8'h00, 2);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        seg_select = 5'd0;
        seg_data   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 30) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_space"}, int'(space_count), 0);
        chk({tag, "_slot"}, int'(near_slot), 0);
        chk({tag, "_fv"}, int'(frame_valid), 0);
        chk({tag, "_err"}, int'(decode_err), 0);
        chk({tag, "_link"}, int'(link_lost), 0);
    endtask

    initial begin
        int p0;

        do_reset();
        chk_zero("reset");

        // Basic frame: space 4, slot 2, blanks elsewhere.
        p0 = n_pulses;
        push_exp(4, 2, 0, 0);
        frame(7'h66, 7'h5B, 7'h00, 7'h00, 7'h00, 8);
        drain("t1_drain");
        chk("t1_pulses", n_pulses - p0, 1);
        chk("t1_space_hold", int'(space_count), 4);

        // Digit 0 too short: no commit, link_lost after TIMEOUT.
        do_reset();
        p0 = n_pulses;
        frame(7'h66, 7'h5B, 7'h00, 7'h00, 7'h00, 3);
        repeat (958) @(posedge clk);
        #1;
        chk("t2_link_early", int'(link_lost), 0);
        chk("t2_space", int'(space_count), 0);
        chk("t2_slot", int'(near_slot), 0);
        repeat (7) @(posedge clk);
        #1;
        chk("t2_link_late", int'(link_lost), 1);
        chk("t2_pulses", n_pulses - p0, 0);

        // Idle to link loss, then a frame clears it on the commit cycle.
        do_reset();
        repeat (1002) @(posedge clk);
        #1;
        chk("t6_link_set", int'(link_lost), 1);
        push_exp(3, 1, 0, 1);
        frame(7'h4F, 7'h06, 7'h3F, 7'h3F, 7'h3F, 8);
        drain("t6_drain");
        chk("t6_link_clear", int'(link_lost), 0);

        // Illegal target digits hold their output and set a sticky error.
        push_exp(7, 1, 1, 0);
        frame(7'h07, 7'h7F, 7'h00, 7'h00, 7'h00, 8);
        push_exp(5, 3, 1, 0);
        frame(7'h6D, 7'h4F, 7'h7D, 7'h6F, 7'h00, 4);
        push_exp(5, 0, 1, 0);
        frame(7'h00, 7'h3F, 7'h00, 7'h00, 7'h00, 8);
        push_exp(5, 1, 1, 0);
        frame(7'h7F, 7'h06, 7'h00, 7'h00, 7'h00, 8);
        drain("t3_drain");

        // Multi-hot selects inside a frame are never accepted.
        p0 = n_pulses;
        push_exp(4, 0, 1, 0);
        put(5'b00001, 8'h66, 8);
        put(5'b00010, 8'h3F, 8);
        put(5'b00011, 8'h5B, 20);
        put(5'b00100, 8'h00, 8);
        put(5'b01000, 8'h00, 8);
        put(5'b11000, 8'h5B, 20);
        chk("t4_no_early", n_pulses - p0, 0);
        put(5'b10000, 8'h00, 8);
        put(5'b00000, 8'h00, 2);
        drain("t4_drain");
        chk("t4_pulses", n_pulses - p0, 1);

        // Reset mid-frame drops partial digits.
        put(5'b00001, 8'h66, 8);
        put(5'b00010, 8'h5B, 8);
        put(5'b00100, 8'h00, 8);
        do_reset();
        chk_zero("t5_reset");
        p0 = n_pulses;
        put(5'b01000, 8'h00, 8);
        put(5'b10000, 8'h00, 8);
        put(5'b00000, 8'h00, 4);
        chk("t5_no_commit", n_pulses - p0, 0);
        push_exp(2, 3, 0, 0);
        frame(7'h5B, 7'h4F, 7'h00, 7'h00, 7'h00, 8);
        drain("t5_drain");
        chk("t5_pulses", n_pulses - p0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receiving end of the parking display's multiplexed 7-segment scan bus. It samples `seg_select`/`seg_data` as driven to the board display and debounces each digit slot. It rebuilds a complete five-digit frame and decodes the free-space count and nearest-slot digits back to binary. It sits beside the display driver for loopback self-check and for a remote status panel, running on the 1 kHz system clock.

## Interface

Parameters:
- `STABLE`, 4: consecutive identical samples required to accept a digit (range 2..15).
- `TIMEOUT`, 1000: cycles without a committed frame before `link_lost` asserts.
- `SPACE_DIGIT`, 0: digit index carrying the free-space count.
- `SLOT_DIGIT`, 1: digit index carrying the nearest free slot.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `seg_select` in 5: one-hot digit enable, active-high; bit i = digit i.
- `seg_data` in 8: segment pattern, active-high; bit0=a … bit6=g, bit7=dp (ignored).
- `space_count` out 3: last committed free-space count.
- `near_slot` out 2: last committed nearest slot.
- `frame_valid` out 1: one-cycle pulse on each commit.
- `decode_err` out 1: sticky; a committed target digit was not a legal value.
- `link_lost` out 1: no commit for `TIMEOUT` cycles.

## Operation

- Sampling: every cycle, register `seg_select` and `seg_data[6:0]`.
  - If the registered sample equals the previous registered sample, the stability counter increments, saturating at `STABLE`.
  - Otherwise the counter reloads to 1.
- A sample is valid only if `seg_select` is exactly one-hot. Zero or multi-hot samples reset the counter to 0 and are never accepted.
- Digit accept: on the cycle the counter reaches `STABLE`, store the 7-bit pattern in slot i and set `seen[i]`. The pattern is accepted once per stable run. A held pattern is not re-accepted, and re-selecting an already-seen slot overwrites it.
- Decode, per slot:
  - 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7, 0x7F=8, 0x6F=9, 0x00=blank.
  - Anything else is illegal.
- FSM:
  - COLLECT: accept digits. When `seen` becomes all-ones, go to COMMIT.
  - COMMIT (one cycle):
    - Space digit: if it decodes to 0..7, load `space_count`. Otherwise hold `space_count` and set `decode_err`.
    - Slot digit: if it decodes to 0..3, load `near_slot`. Otherwise hold `near_slot` and set `decode_err`. Blank counts as illegal for both target digits.
    - Pulse `frame_valid`, clear `seen`, clear the timeout counter and `link_lost`, return to COLLECT.
  - A digit accepted during COMMIT is stored and its `seen` bit remains set after the clear (it starts the next frame).
- Timeout: a counter increments every cycle it is not in COMMIT and saturates at `TIMEOUT`. At `TIMEOUT`, assert `link_lost`.
  - A COMMIT on the same cycle wins: the counter clears and `link_lost` stays 0.
- `decode_err` clears only on reset.

## Timing

- Reset: while `rst`=0 at an edge, the following reset to 0: `space_count`, `near_slot`, `frame_valid`, `decode_err`, `link_lost`, `seen`, all slots, all counters. FSM goes to COLLECT.
- Reset mid-frame discards all partial digits. The first commit after reset needs all five digits re-accepted.
- Input to accept latency: a pattern present at the input on edge N is accepted at edge N+`STABLE` (1 input register plus `STABLE`-1 repeats).
- Accept of the last digit at edge M puts the FSM in COMMIT during M..M+1. Outputs update and `frame_valid`=1 for exactly the cycle after edge M+1.
- With a free-running scan holding each digit ≥`STABLE` cycles, commits occur once per scan cycle. The inter-commit gap equals the scan period ±1 cycle.
- If a digit is held for fewer than `STABLE` cycles, it is never seen and no commit occurs.

## Test plan

- Reset then scan digits 0..4 with patterns {0x66, 0x5B, 0x00, 0x00, 0x00}, each held 8 cycles:
  - Exactly one `frame_valid` pulse after the digit-4 accept.
  - `space_count`=4, `near_slot`=2, `decode_err`=0, `link_lost`=0.
- Same scan, but digit 0 held only 3 cycles (`STABLE`=4):
  - No commit.
  - Outputs stay 0.
  - `link_lost`=1 after 1000 cycles.
- Illegal slot digit 0x7F (8), space digit 0x07 (7):
  - On commit, `space_count`=7, `near_slot` holds its previous value, `decode_err`=1.
  - `decode_err` stays 1 after a later clean frame.
- Multi-hot `seg_select`=5'b00011 for 20 cycles inside a frame: no accept, and `seen` is unchanged.
- Continuous scan, then `rst` low for one edge mid-frame: all outputs 0. The next commit occurs only after a full five-digit scan.
- No scan for 1000 cycles, so `link_lost`=1. A valid frame is then scanned in: `link_lost` falls to 0 in the same cycle `frame_valid` pulses.
